// File: rtl/mem_port_arbiter.sv
// Shares one single-port word RAM between instruction fetch and load/store.
// Latency: 2 cycles grant-to-done with a zero-wait RAM, +1 per wait state; faults answer in 1 cycle.
// Backpressure: requesters hold req until their done strobe; the RAM stalls via mem_ready.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [31:0]       if_rdata,
  output logic              if_fault,
  input  logic              ls_req,
  input  logic              ls_is_load,
  input  logic              ls_is_store,
  input  logic [2:0]        ls_type,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [31:0]       ls_wdata,
  output logic              ls_done,
  output logic [31:0]       ls_rdata,
  output logic              ls_fault,
  output logic              mem_req,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready
);

  typedef enum logic [1:0] {IDLE, IF_BUSY, LS_BUSY, RESP} state_t;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  state_t      state;
  logic [3:0]  starve_cnt;
  logic        lat_is_load;
  logic [2:0]  lat_type;
  logic [1:0]  lat_off;

  logic        fetch_wins;
  logic        grant_ls;
  logic        if_bad;
  logic        ls_bad;
  logic [3:0]  st_we;
  logic [31:0] st_wdata;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ld_data;

  // Arbitration: data normally wins, a starved fetch is forced through.
  always_comb begin
    fetch_wins = if_req && (!ls_req || (starve_cnt == STARVE_MAX));
    grant_ls   = ls_req && !fetch_wins;
    if_bad     = |if_addr[1:0];
  end

  // Load/store legality: access kind, funct3 encoding and natural alignment.
  always_comb begin
    ls_bad = 1'b0;
    if (ls_is_load == ls_is_store) begin
      ls_bad = 1'b1;
    end else if (ls_is_load) begin
      case (ls_type)
        3'b000, 3'b100: ls_bad = 1'b0;
        3'b001, 3'b101: ls_bad = ls_addr[0];
        3'b010:         ls_bad = |ls_addr[1:0];
        default:        ls_bad = 1'b1;
      endcase
    end else begin
      case (ls_type)
        3'b000:  ls_bad = 1'b0;
        3'b001:  ls_bad = ls_addr[0];
        3'b010:  ls_bad = |ls_addr[1:0];
        default: ls_bad = 1'b1;
      endcase
    end
  end

  // Store lane steering: replicate the datum, byte enables pick the lanes.
  always_comb begin
    st_we    = 4'b1111;
    st_wdata = ls_wdata;
    case (ls_type)
      3'b000: begin
        st_we    = 4'b0001 << ls_addr[1:0];
        st_wdata = {4{ls_wdata[7:0]}};
      end
      3'b001: begin
        st_we    = 4'b0011 << {ls_addr[1], 1'b0};
        st_wdata = {2{ls_wdata[15:0]}};
      end
      default: begin
        st_we    = 4'b1111;
        st_wdata = ls_wdata;
      end
    endcase
  end

  // Load formatting from the latched type/offset of the granted access.
  always_comb begin
    byte_sel = mem_rdata[{lat_off, 3'b000} +: 8];
    half_sel = mem_rdata[{lat_off[1], 4'b0000} +: 16];
    case (lat_type)
      3'b000:  ld_data = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  ld_data = {{16{half_sel[15]}}, half_sel};
      3'b100:  ld_data = {24'b0, byte_sel};
      3'b101:  ld_data = {16'b0, half_sel};
      default: ld_data = mem_rdata;
    endcase
  end

  // Main sequencer: grant in IDLE, wait for the RAM, pulse done once, return.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      starve_cnt  <= 4'd0;
      lat_is_load <= 1'b0;
      lat_type    <= 3'd0;
      lat_off     <= 2'd0;
      if_done     <= 1'b0;
      if_rdata    <= 32'd0;
      if_fault    <= 1'b0;
      ls_done     <= 1'b0;
      ls_rdata    <= 32'd0;
      ls_fault    <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 4'd0;
      mem_addr    <= '0;
      mem_wdata   <= 32'd0;
    end else begin
      if_done  <= 1'b0;
      if_fault <= 1'b0;
      ls_done  <= 1'b0;
      ls_fault <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_ls) begin
            if (!if_req) begin
              starve_cnt <= 4'd0;
            end else if (starve_cnt != STARVE_MAX) begin
              starve_cnt <= starve_cnt + 4'd1;
            end
            lat_is_load <= ls_is_load;
            lat_type    <= ls_type;
            lat_off     <= ls_addr[1:0];
            if (ls_bad) begin
              ls_done  <= 1'b1;
              ls_fault <= 1'b1;
              ls_rdata <= 32'd0;
              state    <= RESP;
            end else begin
              mem_req   <= 1'b1;
              mem_addr  <= ls_addr[ADDR_W-1:2];
              mem_we    <= ls_is_store ? st_we : 4'd0;
              mem_wdata <= ls_is_store ? st_wdata : 32'd0;
              state     <= LS_BUSY;
            end
          end else if (fetch_wins) begin
            starve_cnt <= 4'd0;
            if (if_bad) begin
              if_done  <= 1'b1;
              if_fault <= 1'b1;
              if_rdata <= 32'd0;
              state    <= RESP;
            end else begin
              mem_req   <= 1'b1;
              mem_addr  <= if_addr[ADDR_W-1:2];
              mem_we    <= 4'd0;
              mem_wdata <= 32'd0;
              state     <= IF_BUSY;
            end
          end else begin
            starve_cnt <= 4'd0;
          end
        end
        IF_BUSY: begin
          if (mem_ready) begin
            mem_req  <= 1'b0;
            if_rdata <= mem_rdata;
            if_done  <= 1'b1;
            state    <= RESP;
          end
        end
        LS_BUSY: begin
          if (mem_ready) begin
            mem_req  <= 1'b0;
            ls_rdata <= lat_is_load ? ld_data : 32'd0;
            ls_done  <= 1'b1;
            state    <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a response scoreboard and a RAM model.
// Stimulus pushes expected responses/RAM accesses; monitors pop and compare on done / mem_req.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'd0;
  logic        if_done;
  logic [31:0] if_rdata;
  logic        if_fault;
  logic        ls_req = 1'b0;
  logic        ls_is_load = 1'b0;
  logic        ls_is_store = 1'b0;
  logic [2:0]  ls_type = 3'd0;
  logic [31:0] ls_addr = 32'd0;
  logic [31:0] ls_wdata = 32'd0;
  logic        ls_done;
  logic [31:0] ls_rdata;
  logic        ls_fault;
  logic        mem_req;
  logic [3:0]  mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready = 1'b0;

  logic [31:0] ram_word = 32'd0;
  assign mem_rdata = ram_word;

  mem_port_arbiter #(.ADDR_W(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata), .if_fault(if_fault),
    .ls_req(ls_req), .ls_is_load(ls_is_load), .ls_is_store(ls_is_store), .ls_type(ls_type),
    .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata), .ls_fault(ls_fault),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_ls;
    logic [31:0] rdata;
    bit          fault;
    int          due;
  } rsp_t;

  typedef struct {
    logic [29:0] addr;
    logic [3:0]  we;
    logic [31:0] wdata;
  } acc_t;

  rsp_t rsp_q[$];
  acc_t acc_q[$];
  rsp_t mon_e;
  int   vectors = 0;
  int   errors = 0;
  int   wait_n = 0;
  int   wcnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor: every done strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && (if_done || ls_done)) begin
      if (rsp_q.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL unexpected_done: if_done=%b ls_done=%b with nothing expected", if_done, ls_done);
      end else begin
        mon_e = rsp_q.pop_front();
        check("done_port_ls", 32'(ls_done), 32'(mon_e.is_ls));
        check("done_port_if", 32'(if_done), 32'(!mon_e.is_ls));
        if (mon_e.is_ls) begin
          check("ls_rdata", ls_rdata, mon_e.rdata);
          check("ls_fault", 32'(ls_fault), 32'(mon_e.fault));
        end else begin
          check("if_rdata", if_rdata, mon_e.rdata);
          check("if_fault", 32'(if_fault), 32'(mon_e.fault));
        end
        if (mon_e.due >= 0) check("done_cycle", cyc, mon_e.due);
      end
    end
  end

  // RAM model: checks mem_* every cycle of a request, answers after wait_n cycles.
  always @(negedge clk) begin
    if (!rst_n) begin
      mem_ready = 1'b0;
      wcnt = 0;
    end else if (mem_req) begin
      if (acc_q.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL unexpected_mem_req: addr %h we %b with nothing expected", mem_addr, mem_we);
        mem_ready = 1'b1;
      end else begin
        check("mem_addr", 32'(mem_addr), 32'(acc_q[0].addr));
        check("mem_we", 32'(mem_we), 32'(acc_q[0].we));
        if (acc_q[0].we != 4'd0) check("mem_wdata", mem_wdata, acc_q[0].wdata);
        if (wcnt == wait_n) begin
          mem_ready = 1'b1;
          acc_q.delete(0);
        end else begin
          mem_ready = 1'b0;
          wcnt++;
        end
      end
    end else begin
      mem_ready = 1'b0;
      wcnt = 0;
    end
  end

  task automatic push_acc(input logic [29:0] a, input logic [3:0] we, input logic [31:0] wd);
    acc_t m;
    m.addr = a; m.we = we; m.wdata = wd;
    acc_q.push_back(m);
  endtask

  task automatic push_rsp(input bit is_ls, input logic [31:0] rd, input bit f, input int due);
    rsp_t r;
    r.is_ls = is_ls; r.rdata = rd; r.fault = f; r.due = due;
    rsp_q.push_back(r);
  endtask

  task automatic do_ls(input bit ld, input bit st, input logic [2:0] t, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] word, input int w,
                       input logic [31:0] exp_rd, input bit exp_f, input logic [29:0] exp_ma,
                       input logic [3:0] exp_we, input logic [31:0] exp_wd);
    int n;
    @(negedge clk);
    ram_word = word;
    wait_n = w;
    push_rsp(1'b1, exp_rd, exp_f, exp_f ? cyc + 1 : cyc + 2 + w);
    if (!exp_f) push_acc(exp_ma, exp_we, exp_wd);
    ls_req = 1'b1; ls_is_load = ld; ls_is_store = st; ls_type = t; ls_addr = a; ls_wdata = wd;
    n = 0;
    do begin @(negedge clk); n++; end while (!ls_done && n < 50);
    if (!ls_done) begin
      vectors++; errors++;
      $display("FAIL ls_timeout: no ls_done after %0d cycles, addr %h", n, a);
    end
    ls_req = 1'b0; ls_is_load = 1'b0; ls_is_store = 1'b0;
  endtask

  task automatic do_if(input logic [31:0] a, input logic [31:0] word,
                       input bit exp_f, input logic [29:0] exp_ma);
    int n;
    @(negedge clk);
    ram_word = word;
    wait_n = 0;
    push_rsp(1'b0, exp_f ? 32'd0 : word, exp_f, exp_f ? cyc + 1 : cyc + 2);
    if (!exp_f) push_acc(exp_ma, 4'b0000, 32'd0);
    if_req = 1'b1; if_addr = a;
    n = 0;
    do begin @(negedge clk); n++; end while (!if_done && n < 50);
    if (!if_done) begin
      vectors++; errors++;
      $display("FAIL if_timeout: no if_done after %0d cycles, addr %h", n, a);
    end
    if_req = 1'b0;
  endtask

  localparam logic [31:0] W = 32'h80FF7F01;

  initial begin
    int c;
    int n;
    int n_if;
    repeat (3) @(negedge clk);
    check("rst_if_done", 32'(if_done), 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_if_fault", 32'(if_fault), 32'd0);
    check("rst_ls_done", 32'(ls_done), 32'd0);
    check("rst_ls_rdata", ls_rdata, 32'd0);
    check("rst_ls_fault", 32'(ls_fault), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    @(posedge clk); #2 rst_n = 1'b1;

    // stores: lane steering and byte enables
    do_ls(0, 1, 3'b000, 32'h103, 32'h000000AB, 32'd0, 0, 32'd0, 0, 30'h40, 4'b1000, 32'hABABABAB);
    do_ls(0, 1, 3'b001, 32'h102, 32'h1234CDEF, 32'd0, 0, 32'd0, 0, 30'h40, 4'b1100, 32'hCDEFCDEF);
    do_ls(0, 1, 3'b000, 32'h101, 32'h00000055, 32'd0, 0, 32'd0, 0, 30'h40, 4'b0010, 32'h55555555);
    do_ls(0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 32'd0, 0, 32'd0, 0, 30'h40, 4'b1111, 32'hDEADBEEF);
    // loads: selection and extension from word 0x80FF7F01
    do_ls(1, 0, 3'b000, 32'h102, 32'd0, W, 0, 32'hFFFFFFFF, 0, 30'h40, 4'b0000, 32'd0);
    do_ls(1, 0, 3'b100, 32'h102, 32'd0, W, 0, 32'h000000FF, 0, 30'h40, 4'b0000, 32'd0);
    do_ls(1, 0, 3'b001, 32'h102, 32'd0, W, 0, 32'hFFFF80FF, 0, 30'h40, 4'b0000, 32'd0);
    do_ls(1, 0, 3'b101, 32'h102, 32'd0, W, 0, 32'h000080FF, 0, 30'h40, 4'b0000, 32'd0);
    do_ls(1, 0, 3'b010, 32'h100, 32'd0, W, 0, 32'h80FF7F01, 0, 30'h40, 4'b0000, 32'd0);
    do_ls(1, 0, 3'b000, 32'h101, 32'd0, W, 0, 32'h0000007F, 0, 30'h40, 4'b0000, 32'd0);
    do_ls(1, 0, 3'b000, 32'h103, 32'd0, W, 0, 32'hFFFFFF80, 0, 30'h40, 4'b0000, 32'd0);
    do_ls(1, 0, 3'b001, 32'h100, 32'd0, W, 0, 32'h00007F01, 0, 30'h40, 4'b0000, 32'd0);
    // faults: no RAM access, done one cycle after the request is sampled
    do_ls(1, 0, 3'b010, 32'h101, 32'd0, W, 0, 32'd0, 1, 30'h0, 4'b0000, 32'd0);
    do_ls(0, 1, 3'b011, 32'h100, 32'd0, W, 0, 32'd0, 1, 30'h0, 4'b0000, 32'd0);
    do_ls(1, 0, 3'b001, 32'h101, 32'd0, W, 0, 32'd0, 1, 30'h0, 4'b0000, 32'd0);
    do_ls(1, 0, 3'b110, 32'h100, 32'd0, W, 0, 32'd0, 1, 30'h0, 4'b0000, 32'd0);
    do_ls(1, 1, 3'b010, 32'h100, 32'd0, W, 0, 32'd0, 1, 30'h0, 4'b0000, 32'd0);
    do_if(32'h102, W, 1, 30'h0);
    // RAM wait states: mem_* checked every stalled cycle, done one cycle after ready
    do_ls(1, 0, 3'b010, 32'h104, 32'd0, 32'h11223344, 3, 32'h11223344, 0, 30'h41, 4'b0000, 32'd0);
    do_ls(0, 1, 3'b001, 32'h106, 32'h0000BEEF, 32'd0, 3, 32'd0, 0, 30'h41, 4'b1100, 32'hBEEFBEEF);
    do_if(32'h200, 32'h00500093, 0, 30'h80);

    // simultaneous requests: data first, fetch in the following IDLE
    @(negedge clk);
    ram_word = 32'h13579BDF;
    wait_n = 0;
    c = cyc;
    push_rsp(1, 32'h13579BDF, 0, c + 2);
    push_acc(30'h40, 4'b0000, 32'd0);
    push_rsp(0, 32'h13579BDF, 0, c + 5);
    push_acc(30'h82, 4'b0000, 32'd0);
    ls_req = 1; ls_is_load = 1; ls_type = 3'b010; ls_addr = 32'h100;
    if_req = 1; if_addr = 32'h208;
    n = 0;
    while (if_req && n < 40) begin
      @(negedge clk);
      n++;
      if (ls_done) begin ls_req = 0; ls_is_load = 0; end
      if (if_done) if_req = 0;
    end
    if (if_req || ls_req) begin
      vectors++; errors++;
      $display("FAIL simul_timeout: if_req=%b ls_req=%b still pending", if_req, ls_req);
      if_req = 0; ls_req = 0; ls_is_load = 0;
    end

    // starvation: both held; fetch wins after exactly 4 data grants, counter restarts
    @(negedge clk);
    ram_word = 32'h0A0B0C0D;
    c = cyc;
    for (int k = 0; k < 10; k++) begin
      if (k == 4 || k == 9) begin
        push_rsp(0, 32'h0A0B0C0D, 0, c + 2 + 3 * k);
        push_acc(30'hC0, 4'b0000, 32'd0);
      end else begin
        push_rsp(1, 32'h0A0B0C0D, 0, c + 2 + 3 * k);
        push_acc(30'h40, 4'b0000, 32'd0);
      end
    end
    ls_req = 1; ls_is_load = 1; ls_type = 3'b010; ls_addr = 32'h100;
    if_req = 1; if_addr = 32'h300;
    n = 0;
    n_if = 0;
    while (n_if < 2 && n < 100) begin
      @(negedge clk);
      n++;
      if (if_done) n_if++;
    end
    if (n_if < 2) begin
      vectors++; errors++;
      $display("FAIL starve_timeout: saw %0d fetch completions, required 2", n_if);
    end
    ls_req = 0; ls_is_load = 0; if_req = 0;

    // reset during LS_BUSY: access abandoned, no done, block usable afterwards
    @(negedge clk);
    wait_n = 20;
    push_acc(30'h44, 4'b1111, 32'h00000055);
    ls_req = 1; ls_is_store = 1; ls_type = 3'b010; ls_addr = 32'h110; ls_wdata = 32'h55;
    repeat (3) @(negedge clk);
    check("busy_mem_req", 32'(mem_req), 32'd1);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    check("rst_mid_mem_req", 32'(mem_req), 32'd0);
    check("rst_mid_ls_done", 32'(ls_done), 32'd0);
    ls_req = 0; ls_is_store = 0;
    acc_q.delete();
    @(posedge clk); #2 rst_n = 1'b1;
    wait_n = 0;
    do_ls(1, 0, 3'b010, 32'h100, 32'd0, W, 0, W, 0, 30'h40, 4'b0000, 32'd0);

    repeat (4) @(negedge clk);
    check("rsp_q_drained", 32'(rsp_q.size()), 32'd0);
    check("acc_q_drained", 32'(acc_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequential arbiter and access controller that shares the CPU's single-port word-wide data/instruction RAM between the instruction-fetch requester and the load/store requester. Load/store requests carry the decoder's is_load/is_store and funct3 load/store type. The block also handles byte-lane steering, byte enables and load sign/zero extension. It sits between the core's fetch/execute sequencing and the RAM.

## Interface
- ADDR_W, 32, byte-address width; RAM word address is ADDR_W-2 bits
- STARVE_LIMIT, 4, consecutive fetch losses before fetch is forced to win (1..15)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; held until if_done
- if_addr  in  ADDR_W  fetch byte address
- if_done  out  1  one-cycle response strobe
- if_rdata  out  32  fetched word, valid with if_done
- if_fault  out  1  misaligned fetch, valid with if_done
- ls_req  in  1  load/store request; held until ls_done
- ls_is_load / ls_is_store  in  1 each  access kind (exactly one high with ls_req)
- ls_type  in  3  funct3: load 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; store 000 SB, 001 SH, 010 SW
- ls_addr  in  ADDR_W  byte address
- ls_wdata  in  32  store data (low bits used for SB/SH)
- ls_done  out  1  one-cycle response strobe
- ls_rdata  out  32  extended load result, valid with ls_done; 0 for stores
- ls_fault  out  1  misaligned or illegal type, valid with ls_done
- mem_req  out  1  RAM access request, held until mem_ready
- mem_we  out  4  byte enables; 0000 = read
- mem_addr  out  ADDR_W-2  word address
- mem_wdata  out  32  lane-steered write data
- mem_rdata  in  32  read word, valid when mem_ready
- mem_ready  in  1  RAM completes the access this cycle

## Operation
- States: IDLE, IF_BUSY, LS_BUSY, RESP.
- IDLE: if any request is pending, arbitrate:
  - data wins over fetch;
  - exception: fetch wins when starve_cnt == STARVE_LIMIT.
- starve_cnt (4-bit):
  - increments when fetch loses to data while if_req is high;
  - clears when fetch is granted or if_req is low in IDLE;
  - saturates at STARVE_LIMIT.
- Fault check at grant, with no RAM access:
  - fetch fault: if_addr[1:0] != 0.
  - ls fault: LH/LHU/SH with addr[0] = 1; LW/SW with addr[1:0] != 0; load type 011/110/111; store type >= 011; both or neither of is_load/is_store.
  - On fault: go directly to RESP with the fault flag set.
- Grant without fault:
  - register mem_addr = addr[ADDR_W-1:2], mem_we and mem_wdata;
  - assert mem_req;
  - go to IF_BUSY or LS_BUSY.
- Store lanes:
  - SB: mem_we = 0001 << addr[1:0], mem_wdata = {4{wdata[7:0]}}.
  - SH: mem_we = 0011 << (2*addr[1]), mem_wdata = {2{wdata[15:0]}}.
  - SW: mem_we = 1111, mem_wdata = wdata.
- BUSY states: hold mem_req and all mem_* outputs stable until mem_ready is sampled high. Then register the formatted data and enter RESP.
- Load format:
  - select byte mem_rdata[8*addr[1:0] +: 8] or half mem_rdata[16*addr[1] +: 16];
  - sign-extend for LB/LH, zero-extend for LBU/LHU;
  - LW passes the word through.
- RESP: assert the granted port's done strobe for one cycle, with data/fault; then go to IDLE. Requests are ignored in RESP, so a held request is never double-served.

## Timing
- Reset values (async assert, sync to clk on release):
  - state IDLE, starve_cnt 0;
  - all done/fault/req strobes 0;
  - mem_we 0, mem_addr 0, mem_wdata 0, if_rdata 0, ls_rdata 0.
- Request sampled in IDLE at edge N, with RAM ready immediately:
  - mem_req high in cycle N+1;
  - mem_ready high in N+1 → done in N+2;
  - minimum latency 2 cycles.
- RAM wait states add cycles one-for-one.
- Fault responses: done in N+1.
- Requester may drop or change its request in the cycle after done. The next grant is evaluated in the following IDLE cycle, so there is 1 idle cycle between back-to-back accesses.
- Simultaneous if_req and ls_req: one grant only; the loser stays pending with no lost request.
- mem_ready outside BUSY states is ignored.
- Reset mid-access: the transaction is abandoned, mem_req drops immediately and no done is issued.

## Test plan
- SB: addr 0x103, wdata 0x000000AB → mem_addr 0x40, mem_we 1000, mem_wdata 0xABABABAB; ls_done 2 cycles after grant with mem_ready tied high.
- Load extension with mem word 0x80FF7F01:
  - addr 0x102: LB → 0xFFFFFFFF, LBU → 0x000000FF, LH → 0xFFFF80FF, LHU → 0x000080FF;
  - LW at 0x100 → 0x80FF7F01.
- Simultaneous if_req and ls_req from IDLE → data served first; fetch served in the next IDLE; if_rdata equals the RAM word.
- Starvation, STARVE_LIMIT = 4: ls_req re-asserted continuously with if_req high → fetch granted after exactly 4 data grants; starve_cnt then clears.
- Faults:
  - LW at 0x101 → ls_done + ls_fault one cycle after grant, mem_req never high;
  - store type 011 → fault;
  - fetch at 0x102 → if_fault.
- RAM waits 3 cycles with mem_ready low → mem_* stable throughout, done on the cycle after mem_ready.
- rst_n pulsed low during LS_BUSY → mem_req low at once, no ls_done, state IDLE.
